sram_byte_loader: RTL

- Upstream feeder for the 1024x32 on-chip program/data SRAM slave.
- Takes a byte stream (UART/JTAG receive path), packs the bytes little-endian into 32-bit words and writes them through the SRAM's Avalon slave port, starting at a programmed word address.
- After the fill, reads the written region back, compares checksums and reports done/error, so the CPU or boot controller can trust the image before releasing Nios II reset.

---
 rtl/sram_loader_pkg.sv | 27 ++
 rtl/sram_byte_packer.sv | 50 +++++
 rtl/sram_byte_loader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_loader_pkg.sv
// Shared state type, lane constants and the masked-word helper for the SRAM byte loader.
package sram_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_WRITE,
    ST_VERIFY,
    ST_FINISH
  } state_t;

  localparam int         BYTES_PER_WORD = 4;
  localparam logic [3:0] FULL_BE        = 4'hF;

  // Disabled lanes count as zero in both the write checksum and the readback sum.
  function automatic logic [31:0] masked_word(input logic [31:0] word, input logic [3:0] be);
    logic [31:0] result;
    result = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (be[i]) begin
        result[8*i +: 8] = word[8*i +: 8];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/sram_byte_packer.sv
// Packs accepted stream bytes little-endian into one 32-bit word and tracks which lanes hold data.
module sram_byte_packer
  import sram_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic [1:0]  lane,
  output logic [31:0] word,
  output logic [3:0]  be
);

  logic [1:0]  lane_reg;
  logic [31:0] word_reg;
  logic [3:0]  be_reg;
  logic [3:0]  lane_hit;

  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi = gi + 1) begin : g_lane
      assign lane_hit[gi] = accept && (lane_reg == 2'(gi));
    end
  endgenerate

  // Clearing after each write leaves unfilled lanes at zero for a short final word.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      lane_reg <= '0;
      word_reg <= '0;
      be_reg   <= '0;
    end else begin
      if (accept) begin
        lane_reg <= lane_reg + 2'd1;
      end
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        if (lane_hit[i]) begin
          word_reg[8*i +: 8] <= data;
          be_reg[i]          <= 1'b1;
        end
      end
    end
  end

  assign lane = lane_reg;
  assign word = word_reg;
  assign be   = be_reg;

endmodule

// File: rtl/sram_byte_loader.sv
// Byte-stream to SRAM word loader: packs, writes from a base word address, then reads back and
// compares checksums before reporting done/error.
module sram_byte_loader
  import sram_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 13
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  byte_count,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_address,
  output logic [3:0]        m_byteenable,
  output logic [31:0]       m_writedata,
  input  logic [31:0]       m_readdata,
  output logic              m_clken,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       checksum
);

  localparam int              WIDE_W = CNT_W + 1;
  localparam logic [WIDE_W-1:0] DEPTH = WIDE_W'(2 ** ADDR_W);

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W:0]   words_reg;
  logic [CNT_W-1:0]  rem_reg;
  logic [ADDR_W:0]   vcnt_reg;
  logic [3:0]        last_be_reg;
  logic [31:0]       checksum_reg;
  logic [31:0]       rb_sum_reg;
  logic              error_reg;

  logic [WIDE_W-1:0] words_wide;
  logic [WIDE_W-1:0] end_wide;
  logic              start_zero;
  logic              start_ovf;
  logic              accept;
  logic              fill_done;
  logic              verify_last;
  logic [31:0]       capture_word;
  logic [31:0]       rb_final;

  logic [1:0]        pk_lane;
  logic [31:0]       pk_word;
  logic [3:0]        pk_be;

  sram_byte_packer u_packer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_reg == ST_WRITE),
    .accept  (accept),
    .data    (s_data),
    .lane    (pk_lane),
    .word    (pk_word),
    .be      (pk_be)
  );

  // Start decode is done wide enough that base+words never wraps before the range check.
  assign words_wide = (WIDE_W'(byte_count) + WIDE_W'(3)) >> 2;
  assign end_wide   = words_wide + WIDE_W'(base_addr);
  assign start_zero = (byte_count == '0);
  assign start_ovf  = (end_wide > DEPTH);

  assign accept      = s_valid && (state_reg == ST_FILL);
  assign fill_done   = accept && ((pk_lane == 2'd3) || (rem_reg == CNT_W'(1)));
  assign verify_last = (vcnt_reg == words_reg);

  // Reads lag addresses by one cycle, so capture k belongs to word k-1; only the last is partial.
  assign capture_word = masked_word(m_readdata, verify_last ? last_be_reg : FULL_BE);
  assign rb_final     = rb_sum_reg + capture_word;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = (start_zero || start_ovf) ? ST_FINISH : ST_FILL;
        end
      end
      ST_FILL: begin
        if (fill_done) begin
          state_next = ST_WRITE;
        end
      end
      ST_WRITE:  state_next = (rem_reg != '0) ? ST_FILL : ST_VERIFY;
      ST_VERIFY: begin
        if (verify_last) begin
          state_next = ST_FINISH;
        end
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      base_reg     <= '0;
      addr_reg     <= '0;
      words_reg    <= '0;
      rem_reg      <= '0;
      vcnt_reg     <= '0;
      last_be_reg  <= '0;
      checksum_reg <= '0;
      rb_sum_reg   <= '0;
      error_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            checksum_reg <= '0;
            if (start_zero) begin
              error_reg <= 1'b0;
            end else if (start_ovf) begin
              error_reg <= 1'b1;
            end else begin
              error_reg  <= 1'b0;
              base_reg   <= base_addr;
              addr_reg   <= base_addr;
              words_reg  <= words_wide[ADDR_W:0];
              rem_reg    <= byte_count;
              vcnt_reg   <= '0;
              rb_sum_reg <= '0;
            end
          end
        end
        ST_FILL: begin
          if (accept) begin
            rem_reg <= rem_reg - CNT_W'(1);
          end
        end
        ST_WRITE: begin
          checksum_reg <= checksum_reg + masked_word(pk_word, pk_be);
          addr_reg     <= addr_reg + ADDR_W'(1);
          last_be_reg  <= pk_be;
        end
        ST_VERIFY: begin
          vcnt_reg <= vcnt_reg + (ADDR_W + 1)'(1);
          if (vcnt_reg != '0) begin
            rb_sum_reg <= rb_final;
          end
          if (verify_last) begin
            error_reg <= (rb_final != checksum_reg);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    s_ready      = 1'b0;
    m_chipselect = 1'b0;
    m_write      = 1'b0;
    m_address    = '0;
    m_byteenable = '0;
    m_writedata  = '0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_reg)
      ST_FILL: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      ST_WRITE: begin
        busy         = 1'b1;
        m_chipselect = 1'b1;
        m_write      = 1'b1;
        m_address    = addr_reg;
        m_byteenable = pk_be;
        m_writedata  = masked_word(pk_word, pk_be);
      end
      ST_VERIFY: begin
        busy = 1'b1;
        if (!verify_last) begin
          m_chipselect = 1'b1;
          m_address    = base_reg + vcnt_reg[ADDR_W-1:0];
          m_byteenable = FULL_BE;
        end
      end
      ST_FINISH: done = 1'b1;
      default: ;
    endcase
  end

  assign m_clken  = 1'b1;
  assign error    = error_reg;
  assign checksum = checksum_reg;

endmodule
